// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock, signed or unsigned per operation.
// The product of two WIDTH-bit operands takes WIDTH cycles through a single 2*WIDTH-bit adder.
module seq_multiplier #(
    parameter  int WIDTH = 8,
    localparam int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     opa,
    input  logic [WIDTH-1:0]     opb,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 dbg_state
);

    // Handshake: start is taken on a rising edge only while busy=0. The operation then
    // runs for WIDTH edges with busy=1; on the last edge done pulses for one cycle
    // (busy=0 again), result updates, and a start present in that cycle is accepted.

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   acc;
    logic [CNTW-1:0]      cnt;
    logic                 neg;

    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_sum;

    // Magnitudes stay WIDTH-bit unsigned, so negating the most negative value
    // yields 2^(WIDTH-1) as an unsigned number without overflow.
    always_comb begin
        abs_a   = (signed_mode && opa[WIDTH-1]) ? (~opa + 1'b1) : opa;
        abs_b   = (signed_mode && opb[WIDTH-1]) ? (~opb + 1'b1) : opb;
        addend  = mag_b[0] ? mag_a : '0;
        acc_sum = acc + addend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mag_a  <= '0;
            mag_b  <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_a <= {{WIDTH{1'b0}}, abs_a};
                        mag_b <= abs_b;
                        acc   <= '0;
                        cnt   <= CNTW'(WIDTH);
                        neg   <= signed_mode & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_sum;
                    mag_a <= mag_a << 1;
                    mag_b <= mag_b >> 1;
                    cnt   <= cnt - CNTW'(1);
                    if (cnt == CNTW'(1)) begin
                        // Negating a zero accumulator gives zero, so a zero operand never yields a nonzero result.
                        result <= neg ? (~acc_sum + 1'b1) : acc_sum;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: WIDTH=8 instance checked cycle by cycle against a queue-based
// handshake model, plus a WIDTH=16 instance exercised with directed operations.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [7:0]  opa = '0;
    logic [7:0]  opb = '0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        dbg_state;

    logic        w_start = 1'b0;
    logic        w_signed = 1'b0;
    logic [15:0] w_opa = '0;
    logic [15:0] w_opb = '0;
    logic        w_busy;
    logic        w_done;
    logic [31:0] w_result;
    logic        w_dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [15:0] exp_q[$];
    int          due_q[$];
    logic [15:0] last_result = '0;

    seq_multiplier #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result),
        .dbg_state(dbg_state)
    );

    seq_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(w_start), .signed_mode(w_signed),
        .opa(w_opa), .opb(w_opb), .busy(w_busy), .done(w_done), .result(w_result),
        .dbg_state(w_dbg_state)
    );

    // Clock and cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model_prod(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [15:0] ea;
        logic [15:0] eb;
        ea = s ? {{8{a[7]}}, a} : {8'h00, a};
        eb = s ? {{8{b[7]}}, b} : {8'h00, b};
        return 16'(ea * eb);
    endfunction

    // Scoreboard: inputs and outputs are both stable at the falling edge.
    always @(negedge clk) begin
        logic exp_busy;
        logic exp_done;
        if (cyc > 0) begin
            exp_busy = (due_q.size() > 0) && (cyc < due_q[0]);
            exp_done = (due_q.size() > 0) && (cyc == due_q[0]);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            if (exp_done) begin
                check("result_on_done", result, exp_q[0]);
                last_result = exp_q.pop_front();
                void'(due_q.pop_front());
            end else begin
                check("result_hold", result, last_result);
            end
            if (rst) begin
                exp_q.delete();
                due_q.delete();
                last_result = '0;
            end else if (start && !((due_q.size() > 0) && (cyc < due_q[0]))) begin
                exp_q.push_back(model_prod(opa, opb, signed_mode));
                due_q.push_back(cyc + 1 + 8);
            end
        end
    end

    // Driver: called at posedge+#1; waits for idle, presents one start pulse,
    // then scrambles the operand inputs while the operation runs.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) check("issue_wait_timeout", 1, 0);
        start = 1'b1;
        opa = a;
        opb = b;
        signed_mode = s;
        @(posedge clk); #1;
        start = 1'b0;
        opa = 8'($urandom);
        opb = 8'($urandom);
        signed_mode = 1'($urandom);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [31:0] exp, input string tag);
        int n;
        w_start = 1'b1;
        w_opa = a;
        w_opb = b;
        w_signed = s;
        @(posedge clk); #1;
        w_start = 1'b0;
        w_opa = 16'($urandom);
        w_opb = 16'($urandom);
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (w_done === 1'b1) break;
        end
        check({tag, "_latency"}, 64'(n), 64'd16);
        check(tag, w_result, exp);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, w_done, 1'b0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Directed operations from the test plan
        issue(8'd13,  8'd11,  1'b0);
        issue(8'd255, 8'd255, 1'b0);
        issue(8'd0,   8'd200, 1'b0);
        issue(8'hFD,  8'd5,   1'b1);
        issue(8'h80,  8'h80,  1'b1);
        issue(8'h80,  8'h7F,  1'b1);
        issue(8'hFF,  8'hFF,  1'b1);
        issue(8'h00,  8'h80,  1'b1);
        issue(8'h80,  8'h00,  1'b1);

        // start held high with operands changing every cycle
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            opa = 8'($urandom);
            opb = 8'($urandom);
            signed_mode = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        start = 1'b0;

        // Reset four cycles into an operation, then a fresh operation
        issue(8'd100, 8'd3, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        issue(8'd6, 8'd7, 1'b0);

        // Random operations
        for (int i = 0; i < 20; i++)
            issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("drain_timeout", 1, 0);
        repeat (3) @(posedge clk);
        #1;

        // WIDTH=16 instance
        run16(16'd40000, 16'd50000, 1'b0, 32'h7735_9400, "w16_unsigned");
        run16(16'h8000,  16'h8000,  1'b1, 32'h4000_0000, "w16_min_sq");
        run16(16'd1234,  16'hFFFB,  1'b1, 32'hFFFF_E7E6, "w16_neg");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end

endmodule
